// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the pipelined MIPS core.
// Holds the word-addressed PC, issues instruction reads over a req/ack
// port and loads the IF/ID register consumed by decode. A redirect from
// decode takes effect after one delay-slot instruction.
// Ports:
//   clock, reset (async, active-low)
//   is_if_stall             : freeze IF/ID and PC
//   id_if_selpcsource/type  : redirect request and target select
//   id_if_rega/pcimd2ext/pcindex : candidate redirect targets
//   if_mc_req/if_mc_addr    : instruction read request (decoded from state/pc)
//   mc_if_ack/mc_if_data    : read data return
//   if_id_instruc/nextpc    : IF/ID register (registered)
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        is_if_stall,
    input  logic        id_if_selpcsource,
    input  logic [1:0]  id_if_selpctype,
    input  logic [31:0] id_if_rega,
    input  logic [31:0] id_if_pcimd2ext,
    input  logic [31:0] id_if_pcindex,
    output logic        if_mc_req,
    output logic [31:0] if_mc_addr,
    input  logic        mc_if_ack,
    input  logic [31:0] mc_if_data,
    output logic [31:0] if_id_instruc,
    output logic [31:0] if_id_nextpc
);

    typedef enum logic {REQ, HELD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pend_pc;
    logic        pend_v;
    logic [31:0] held_word;

    logic        redir;
    logic [31:0] redir_tgt;
    logic [31:0] pc_inc;
    logic [31:0] next_pc;

    always_comb begin
        redir_tgt = id_if_pcimd2ext;
        case (id_if_selpctype)
            2'b01:   redir_tgt = id_if_rega;
            2'b10:   redir_tgt = id_if_pcindex;
            default: redir_tgt = id_if_pcimd2ext;
        endcase
    end

    // A redirect is only captured on a cycle where IF/ID moves on, so each
    // decoded instruction contributes at most once.
    assign redir  = id_if_selpcsource && (id_if_selpctype != 2'b11) && !is_if_stall;
    assign pc_inc = pc + 32'd1;

    // Same-cycle redirect beats the pending one: it belongs to the newer
    // instruction, whose delay slot is the word being accepted right now.
    assign next_pc = redir  ? redir_tgt :
                     pend_v ? pend_pc   : pc_inc;

    assign if_mc_req  = (state == REQ);
    assign if_mc_addr = pc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= REQ;
            pc            <= RESET_PC;
            pend_pc       <= RESET_PC;
            pend_v        <= 1'b0;
            held_word     <= 32'h0;
            if_id_instruc <= NOP;
            if_id_nextpc  <= RESET_PC;
        end else begin
            if (redir) begin
                pend_pc <= redir_tgt;
                pend_v  <= 1'b1;
            end
            case (state)
                REQ: begin
                    if (mc_if_ack) begin
                        if (!is_if_stall) begin
                            if_id_instruc <= mc_if_data;
                            if_id_nextpc  <= pc_inc;
                            pc            <= next_pc;
                            // next_pc already consumed any redirect; this
                            // overrides the capture above.
                            pend_v        <= 1'b0;
                        end else begin
                            // Park the word so the stall costs no re-fetch.
                            held_word <= mc_if_data;
                            state     <= HELD;
                        end
                    end else if (!is_if_stall) begin
                        if_id_instruc <= NOP;
                    end
                end
                HELD: begin
                    if (!is_if_stall) begin
                        if_id_instruc <= held_word;
                        if_id_nextpc  <= pc_inc;
                        pc            <= next_pc;
                        pend_v        <= 1'b0;
                        state         <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

endmodule
